// File: rtl/levinson_control.sv
// levinson_control: sequencer for the Levinson-Durbin recursion, driving
// the autocorrelation/coefficient RAM addresses and the MAC/divider strobes.
module levinson_control #(
   parameter int ORDER = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       div_done,
   output logic       busy,
   output logic       done,
   output logic [3:0] raddr,
   output logic [3:0] a_raddr,
   output logic [3:0] m_raddr,
   output logic [3:0] waddr,
   output logic       we,
   output logic       bank,
   output logic [3:0] order_i,
   output logic       mac_clr,
   output logic       mac_en,
   output logic       sel_r,
   output logic       div_start,
   output logic       k_we,
   output logic       err_load,
   output logic       err_upd
);
   typedef enum logic [2:0] {IDLE, INIT, ACC, DIV, KWR, UPD, ERR, DONE} state_t;
   localparam logic [3:0] ORD = 4'(ORDER);
   state_t     state, state_n;
   logic [3:0] i, j;
   logic       div_first;
   logic       acc_last, upd_last;
   assign acc_last = j == i;
   assign upd_last = j == i - 4'd1;
   assign order_i  = i;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         i         <= 4'd0;
         j         <= 4'd0;
         bank      <= 1'b0;
         div_first <= 1'b0;
      end else begin
         state     <= state_n;
         // DIV is only entered from ACC, so this marks its first cycle
         div_first <= state == ACC;
         case (state)
            INIT: begin
               i    <= 4'd1;
               j    <= 4'd1;
               bank <= 1'b0;
            end
            ACC: j <= acc_last ? 4'd1 : j + 4'd1;
            UPD: j <= upd_last ? j : j + 4'd1;
            ERR: begin
               bank <= ~bank;
               if (i != ORD) begin
                  i <= i + 4'd1;
                  j <= 4'd1;
               end
            end
            default: ;
         endcase
      end
   end
   always_comb begin
      state_n   = state;
      busy      = state != IDLE;
      done      = state == DONE;
      raddr     = 4'd0;
      a_raddr   = 4'd0;
      m_raddr   = 4'd0;
      waddr     = 4'd0;
      we        = 1'b0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      sel_r     = 1'b0;
      div_start = 1'b0;
      k_we      = 1'b0;
      err_load  = 1'b0;
      err_upd   = 1'b0;
      case (state)
         IDLE: state_n = start ? INIT : IDLE;
         INIT: begin
            err_load = 1'b1;
            mac_clr  = 1'b1;
            state_n  = ACC;
         end
         ACC: begin
            mac_en  = 1'b1;
            sel_r   = acc_last;
            raddr   = acc_last ? i : i - j;
            a_raddr = acc_last ? 4'd0 : j;
            state_n = acc_last ? DIV : ACC;
         end
         DIV: begin
            div_start = div_first;
            state_n   = (div_done && !div_first) ? KWR : DIV;
         end
         KWR: begin
            k_we    = 1'b1;
            we      = 1'b1;
            waddr   = i;
            state_n = (i > 4'd1) ? UPD : ERR;
         end
         UPD: begin
            a_raddr = j;
            m_raddr = i - j;
            we      = 1'b1;
            waddr   = j;
            state_n = upd_last ? ERR : UPD;
         end
         ERR: begin
            err_upd = 1'b1;
            mac_clr = 1'b1;
            state_n = (i == ORD) ? DONE : ACC;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_levinson_control.sv
// tb_levinson_control: directed checks of the Levinson sequencer at ORDER=10 and ORDER=1.
module tb_levinson_control;
   logic clk = 0, reset = 1;
   logic s10 = 0, dd10 = 0, s1 = 0, dd1 = 0;
   logic busy10, done10, we10, bank10, mac_clr10, mac_en10, sel_r10, div_start10, k_we10, err_load10, err_upd10;
   logic [3:0] raddr10, a_raddr10, m_raddr10, waddr10, order_i10;
   logic busy1, done1, we1, bank1, mac_clr1, mac_en1, sel_r1, div_start1, k_we1, err_load1, err_upd1;
   logic [3:0] raddr1, a_raddr1, m_raddr1, waddr1, order_i1;
   logic [30:0] obs10, obs1;
   int cmp = 0, err = 0, cyc = 0, d10 = 1, due10 = -1, due1 = -1;

   always #5 clk = ~clk;

   levinson_control #(.ORDER(10)) dut10 (
      .clk(clk), .reset(reset), .start(s10), .div_done(dd10), .busy(busy10), .done(done10),
      .raddr(raddr10), .a_raddr(a_raddr10), .m_raddr(m_raddr10), .waddr(waddr10), .we(we10),
      .bank(bank10), .order_i(order_i10), .mac_clr(mac_clr10), .mac_en(mac_en10), .sel_r(sel_r10),
      .div_start(div_start10), .k_we(k_we10), .err_load(err_load10), .err_upd(err_upd10));

   levinson_control #(.ORDER(1)) dut1 (
      .clk(clk), .reset(reset), .start(s1), .div_done(dd1), .busy(busy1), .done(done1),
      .raddr(raddr1), .a_raddr(a_raddr1), .m_raddr(m_raddr1), .waddr(waddr1), .we(we1),
      .bank(bank1), .order_i(order_i1), .mac_clr(mac_clr1), .mac_en(mac_en1), .sel_r(sel_r1),
      .div_start(div_start1), .k_we(k_we1), .err_load(err_load1), .err_upd(err_upd1));

   assign obs10 = {busy10, done10, mac_clr10, mac_en10, sel_r10, div_start10, k_we10, err_load10,
                   err_upd10, we10, bank10, raddr10, a_raddr10, m_raddr10, waddr10, order_i10};
   assign obs1  = {busy1, done1, mac_clr1, mac_en1, sel_r1, div_start1, k_we1, err_load1,
                   err_upd1, we1, bank1, raddr1, a_raddr1, m_raddr1, waddr1, order_i1};

   // Advance to the middle of the next cycle; model the dividers (latency d10 and 1).
   task automatic step();
      @(negedge clk);
      cyc++;
      if (div_start10) due10 = cyc + d10;
      if (div_start1) due1 = cyc + 1;
      dd10 = (cyc == due10);
      dd1  = (cyc == due1);
   endtask

   task automatic test_reset();
      reset = 1;
      s10 = 1;
      s1 = 1;
      repeat (3) step();
      cmp++;
      if (obs10 !== 31'd0) begin err++; $display("FAIL reset10: got %h want 0", obs10); end
      cmp++;
      if (obs1 !== 31'd0) begin err++; $display("FAIL reset1: got %h want 0", obs1); end
      s10 = 0;
      s1 = 0;
      reset = 0;
      step();
      cmp++;
      if (busy10 !== 1'b0) begin err++; $display("FAIL reset_start_priority: busy %b want 0", busy10); end
   endtask

   task automatic test_order1();
      logic [30:0] exp1 [8];
      exp1[0] = {11'b10100001000, 20'h00000};
      exp1[1] = {11'b10011000000, 20'h10001};
      exp1[2] = {11'b10000100000, 20'h00001};
      exp1[3] = {11'b10000000000, 20'h00001};
      exp1[4] = {11'b10000010010, 20'h00011};
      exp1[5] = {11'b10100000100, 20'h00001};
      exp1[6] = {11'b11000000001, 20'h00001};
      exp1[7] = {11'b00000000001, 20'h00001};
      s1 = 1;
      for (int n = 0; n < 8; n++) begin
         step();
         s1 = 0;
         cmp++;
         if (obs1 !== exp1[n]) begin err++; $display("FAIL order1_c%0d: got %h want %h", n + 1, obs1, exp1[n]); end
      end
   endtask

   task automatic run_full(input int d, input bit inject, input bit poke, input int exp_lat);
      int lat = 0, k = 1, nds = 0, ntog = 0, dlen = 0, bad_div = 0, bad_busy = 0, bad_ord = 0, na = 0, nu = 0;
      logic pbank, in_div = 0;
      logic [3:0] ar [3], aa [3], ua [3], um [3], uw [3];
      for (int n = 0; n < 3; n++) begin ar[n] = 0; aa[n] = 0; ua[n] = 0; um[n] = 0; uw[n] = 0; end
      d10 = d;
      pbank = bank10;
      s10 = 1;
      step();
      lat = 1;
      while (!done10 && lat < 400) begin
         s10 = 0;
         if (!busy10) bad_busy++;
         if (lat > 1 && order_i10 !== 4'(k)) bad_ord++;
         if (bank10 !== pbank) ntog++;
         pbank = bank10;
         if (div_start10) nds++;
         if (in_div && k_we10) begin
            if (dlen != d + 1) bad_div++;
            if (waddr10 !== 4'(k)) bad_div++;
            in_div = 0;
            dlen = 0;
         end else if (in_div) begin
            dlen++;
            if (div_start10 !== (dlen == 1)) bad_div++;
            if ({done10, mac_clr10, mac_en10, sel_r10, k_we10, err_load10, err_upd10, we10,
                 raddr10, a_raddr10, m_raddr10, waddr10} !== 24'd0) bad_div++;
         end else if (div_start10) bad_div++;
         if (sel_r10) in_div = 1;
         if (k == 3 && mac_en10) begin
            if (na < 3) begin ar[na] = raddr10; aa[na] = a_raddr10; end
            na++;
         end
         if (k == 3 && we10 && !k_we10) begin
            if (nu < 3) begin ua[nu] = a_raddr10; um[nu] = m_raddr10; uw[nu] = waddr10; end
            nu++;
         end
         if (err_upd10) k++;
         if (inject && (mac_en10 || (in_div && dlen == 1))) dd10 = 1;
         if (poke && we10 && !k_we10) s10 = 1;
         step();
         lat++;
      end
      s10 = 0;
      if (bank10 !== pbank) ntog++;
      cmp++;
      if (lat !== exp_lat) begin err++; $display("FAIL done_latency: got %0d want %0d", lat, exp_lat); end
      cmp++;
      if (busy10 !== 1'b1) begin err++; $display("FAIL busy_at_done: got %b want 1", busy10); end
      cmp++;
      if (nds !== 10) begin err++; $display("FAIL div_start_count: got %0d want 10", nds); end
      cmp++;
      if (ntog !== 10) begin err++; $display("FAIL bank_toggles: got %0d want 10", ntog); end
      cmp++;
      if (bad_div !== 0) begin err++; $display("FAIL div_phase: got %0d bad want 0", bad_div); end
      cmp++;
      if (bad_busy !== 0) begin err++; $display("FAIL busy_window: got %0d bad want 0", bad_busy); end
      cmp++;
      if (bad_ord !== 0) begin err++; $display("FAIL order_i: got %0d bad want 0", bad_ord); end
      cmp++;
      if (na !== 3 || {ar[0], ar[1], ar[2]} !== 12'h213 || {aa[0], aa[1], aa[2]} !== 12'h120)
         begin err++; $display("FAIL acc_i3: got n=%0d r=%h%h%h a=%h%h%h want n=3 r=213 a=120", na, ar[0], ar[1], ar[2], aa[0], aa[1], aa[2]); end
      cmp++;
      if (nu !== 2 || {ua[0], um[0], uw[0], ua[1], um[1], uw[1]} !== 24'h121212)
         begin err++; $display("FAIL upd_i3: got n=%0d %h%h%h%h%h%h want n=2 121212", nu, ua[0], um[0], uw[0], ua[1], um[1], uw[1]); end
      step();
      cmp++;
      if (busy10 !== 1'b0 || done10 !== 1'b0) begin err++; $display("FAIL after_done: got busy=%b done=%b want 0 0", busy10, done10); end
      step();
      cmp++;
      if (busy10 !== 1'b0) begin err++; $display("FAIL no_queued_start: got busy=%b want 0", busy10); end
   endtask

   task automatic test_order10();
      run_full(1, 0, 0, 142);
   endtask

   task automatic test_back_to_back();
      run_full(1, 0, 1, 142);
      run_full(1, 0, 0, 142);
   endtask

   task automatic test_div_latency();
      run_full(5, 1, 0, 182);
   endtask

   task automatic test_reset_mid();
      int n = 0, ndone = 0;
      d10 = 1;
      s10 = 1;
      step();
      s10 = 0;
      while (!(div_start10 && order_i10 == 4'd4) && n < 300) begin
         step();
         n++;
      end
      cmp++;
      if (n >= 300) begin err++; $display("FAIL reach_i4_div: got timeout want DIV of i=4"); end
      reset = 1;
      step();
      reset = 0;
      cmp++;
      if (obs10 !== 31'd0) begin err++; $display("FAIL abort_outputs: got %h want 0", obs10); end
      repeat (200) begin
         if (done10) ndone++;
         step();
      end
      cmp++;
      if (ndone !== 0) begin err++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
      run_full(1, 0, 0, 142);
   endtask

   initial begin
      test_reset();
      test_order1();
      test_order10();
      test_back_to_back();
      test_div_latency();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule

// File: doc/levinson_control.md
LEVINSON_CONTROL -- requirements
Module: levinson_control

Interface
REQ-001 The block SHALL have parameter ORDER, default 10, giving the LPC order P; the legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: autocorrelation R[0..P] complete; sampled only in IDLE.
REQ-005 The block SHALL have port div_done, input, 1 bit: divider result k_i valid.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse, coefficients a[1..P] final.
REQ-008 The block SHALL have port raddr, output, 4 bits: autocorrelation RAM read address.
REQ-009 The block SHALL have port a_raddr, output, 4 bits: coefficient read address j.
REQ-010 The block SHALL have port m_raddr, output, 4 bits: mirror coefficient read address i-j.
REQ-011 The block SHALL have port waddr, output, 4 bits: coefficient write address.
REQ-012 The block SHALL have port we, output, 1 bit: coefficient write enable.
REQ-013 The block SHALL have port bank, output, 1 bit: coefficient bank to read; writes go to ~bank.
REQ-014 The block SHALL have port order_i, output, 4 bits: current recursion index i.
REQ-015 The block SHALL have ports mac_clr, mac_en, sel_r, div_start, k_we, err_load and err_upd, each output, 1 bit: datapath strobes, as defined below.

Function
REQ-016 The FSM SHALL have states IDLE, INIT, ACC, DIV, KWR, UPD, ERR and DONE.
REQ-017 In IDLE, start=1 SHALL move the FSM to INIT on the next cycle.
REQ-018 In INIT (1 cycle), outputs SHALL be err_load=1, mac_clr=1, raddr=0; the block SHALL set i=1 and bank=0, then go to ACC with j=1.
REQ-019 In ACC, each cycle with j<i SHALL drive raddr=i-j, a_raddr=j, mac_en=1, and increment j.
REQ-020 In ACC, the cycle with j==i SHALL drive raddr=i, sel_r=1, mac_en=1, then go to DIV; ACC therefore lasts exactly i cycles, which is 1 cycle for i=1.
REQ-021 In DIV, div_start SHALL be high on the entry cycle only.
REQ-022 In DIV, div_done SHALL be ignored on the entry cycle; div_done=1 on any later DIV cycle SHALL move the FSM to KWR.
REQ-023 With divider latency D (div_done D cycles after div_start), DIV SHALL occupy D+1 cycles.
REQ-024 KWR (1 cycle) SHALL drive k_we=1, we=1, waddr=i.
REQ-025 After KWR, the FSM SHALL go to UPD if i>1, else to ERR.
REQ-026 In UPD, for j=1..i-1, one per cycle, the block SHALL drive a_raddr=j, m_raddr=i-j, we=1, waddr=j; after j=i-1 it SHALL go to ERR.
REQ-027 ERR (1 cycle) SHALL drive err_upd=1 and mac_clr=1 and toggle bank at the cycle end.
REQ-028 After ERR, if i==ORDER the FSM SHALL go to DONE; otherwise it SHALL set i=i+1, j=1 and go to ACC.
REQ-029 DONE (1 cycle) SHALL drive done=1, then return to IDLE.
REQ-030 Per index i, the block SHALL spend 2i+D+2 cycles.
REQ-031 With start accepted at cycle c0, done SHALL be high at cycle c0 + 2 + P(P+1) + P(D+2).
REQ-032 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-033 div_done outside DIV SHALL be ignored.
REQ-034 div_done held high SHALL not skip the ignored entry cycle.
REQ-035 All strobes not listed for a state SHALL be 0 in that state.
REQ-036 All addresses not listed for a state SHALL be 0 in that state.
REQ-037 order_i SHALL equal i in every state; it SHALL hold its last value in DONE and IDLE.
REQ-038 The i and j counters SHALL be 4 bits.
REQ-039 The i and j counters SHALL never exceed ORDER.

Reset
REQ-040 reset=1 SHALL, at the next rising edge, force IDLE with busy=0, done=0, all strobes 0, all addresses 0, bank=0, order_i=0, i=j=0.
REQ-041 reset SHALL take priority over start and div_done.
REQ-042 A reset asserted mid-recursion SHALL abort the recursion without asserting done.

Verification
REQ-043 The bench SHALL cover: ORDER=10, D=1, start at c0 -> done at c0+142 exactly; busy high from c0+1 to c0+142; 10 div_start pulses; bank toggles 10 times.
REQ-044 The bench SHALL cover: ORDER=1, D=1 -> INIT, ACC (raddr=1, sel_r=1), DIV×2, KWR (waddr=1), ERR, DONE; done at c0+7; no UPD cycle.
REQ-045 The bench SHALL cover: i=3 iteration -> ACC raddr sequence 2,1,3 with a_raddr 1,2; UPD pairs (a_raddr, m_raddr)=(1,2),(2,1) with waddr 1,2.
REQ-046 The bench SHALL cover: D=5, div_done also pulsed in ACC and on the DIV entry cycle -> both ignored; DIV lasts 6 cycles each index.
REQ-047 The bench SHALL cover: start pulsed during UPD -> no effect; after done, a new start -> second run identical in timing.
REQ-048 The bench SHALL cover: reset asserted during DIV of i=4 -> next cycle IDLE with all outputs 0; done never pulses; a subsequent start runs a full recursion normally.
